// File: rtl/lane_pkg.sv
// Shared constants and helpers for the lane sensor conditioner.
// Lane order: 0 = xL, 1 = xR, 2 = yU, 3 = yD.
package lane_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_XL   = 0;
    localparam int LANE_XR   = 1;
    localparam int LANE_YU   = 2;
    localparam int LANE_YD   = 3;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int JAM_CYCLES_DEF   = 12;
    localparam int STUCK_CYCLES_DEF = 255;

    // Bits needed to hold values 0..max_val, i.e. ceil(log2(max_val+1)), minimum 1.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lane_filter.sv
// Single-lane conditioner: 2-flop synchroniser, debounce, occupancy/jam timer.
// Stuck-detector supervision is included when LANE_STUCK_DETECT_EN is defined.
module lane_filter
    import lane_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int JAM_CYCLES   = JAM_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic det_raw,
    input  logic fault_clr,
    output logic car_present,
    output logic jam,
    output logic fault
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int OW = cnt_width(JAM_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [OW-1:0] OCC_MAX  = OW'(JAM_CYCLES);

    logic          sync1_reg, sync2_reg;
    logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
    logic [OW-1:0] occ_cnt_reg, occ_cnt_next;
    logic          car_reg, car_next;
    logic          jam_reg, jam_next;
    logic          fault_hold;

`ifdef LANE_STUCK_DETECT_EN
    localparam int SW = cnt_width(STUCK_CYCLES);
    localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] stuck_cnt_reg, stuck_cnt_next;
    logic          fault_reg, fault_next;
    logic          stuck_hit;

    assign stuck_hit = sync2_reg && (stuck_cnt_reg == STUCK_LAST);

    // A new stuck event beats a simultaneous clear; a clear restarts the count.
    always_comb begin
        fault_next     = fault_reg;
        stuck_cnt_next = stuck_cnt_reg;
        if (stuck_hit) begin
            fault_next = 1'b1;
        end else if (fault_clr) begin
            fault_next = 1'b0;
        end
        if (!sync2_reg || (fault_clr && !stuck_hit)) begin
            stuck_cnt_next = '0;
        end else if (stuck_cnt_reg != STUCK_MAX) begin
            stuck_cnt_next = stuck_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stuck_cnt_reg <= '0;
            fault_reg     <= 1'b0;
        end else begin
            stuck_cnt_reg <= stuck_cnt_next;
            fault_reg     <= fault_next;
        end
    end

    assign fault_hold = fault_next;
    assign fault      = fault_reg;
`else
    logic unused_stuck_inputs;
    assign unused_stuck_inputs = fault_clr ^ (STUCK_CYCLES != 0);
    assign fault_hold = 1'b0;
    assign fault      = 1'b0;
`endif

    always_comb begin
        deb_cnt_next = deb_cnt_reg;
        occ_cnt_next = occ_cnt_reg;
        car_next     = car_reg;
        jam_next     = 1'b0;
        if (fault_hold) begin
            deb_cnt_next = '0;
            occ_cnt_next = '0;
            car_next     = 1'b0;
        end else begin
            if (sync2_reg == car_reg) begin
                deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                car_next     = sync2_reg;
                deb_cnt_next = '0;
            end else begin
                deb_cnt_next = deb_cnt_reg + 1'b1;
            end
            // Occupancy age saturates; jam needs a full JAM_CYCLES of prior occupancy.
            if (car_next) begin
                occ_cnt_next = (occ_cnt_reg == OCC_MAX) ? occ_cnt_reg : occ_cnt_reg + 1'b1;
            end else begin
                occ_cnt_next = '0;
            end
            jam_next = car_next && (occ_cnt_reg == OCC_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            deb_cnt_reg <= '0;
            occ_cnt_reg <= '0;
            car_reg     <= 1'b0;
            jam_reg     <= 1'b0;
        end else begin
            sync1_reg   <= det_raw;
            sync2_reg   <= sync1_reg;
            deb_cnt_reg <= deb_cnt_next;
            occ_cnt_reg <= occ_cnt_next;
            car_reg     <= car_next;
            jam_reg     <= jam_next;
        end
    end

    assign car_present = car_reg;
    assign jam         = jam_reg;

endmodule

// File: rtl/lane_sensor_conditioner.sv
// Conditions four raw loop detectors into car_present (s1) and jam (s2) levels.
// Define LANE_STUCK_DETECT_EN to enable stuck-detector fault flags.
module lane_sensor_conditioner
    import lane_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int JAM_CYCLES   = JAM_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_LANES-1:0] det_raw,
    input  logic                 fault_clr,
    output logic [NUM_LANES-1:0] car_present,
    output logic [NUM_LANES-1:0] jam,
    output logic [NUM_LANES-1:0] fault
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            lane_filter #(
                .DEB_CYCLES  (DEB_CYCLES),
                .JAM_CYCLES  (JAM_CYCLES),
                .STUCK_CYCLES(STUCK_CYCLES)
            ) u_lane_filter (
                .clk        (clk),
                .reset_n    (reset_n),
                .det_raw    (det_raw[gi]),
                .fault_clr  (fault_clr),
                .car_present(car_present[gi]),
                .jam        (jam[gi]),
                .fault      (fault[gi])
            );
        end
    endgenerate

endmodule
